// File: rtl/mux2x1_arbiter.sv
// ============================================================================
// mux2x1_arbiter : round-robin two-lane arbiter with a registered output stage
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module mux2x1_arbiter #(
    parameter int WIDTH     = 8,
    parameter int MAX_BURST = 4,
    parameter int CNT_W     = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in0,
    input  logic             valid0,
    output logic             ready0,
    input  logic [WIDTH-1:0] in1,
    input  logic             valid1,
    output logic             ready1,
    output logic [WIDTH-1:0] out,
    output logic             valid_out,
    input  logic             out_ready,
    output logic             sel
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] C_LAST_BEAT = CNT_W'(MAX_BURST - 1);
    localparam logic [CNT_W-1:0] C_ONE       = CNT_W'(1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_burst_cnt;
    logic [CNT_W-1:0]   w_burst_cnt_nxt;
    logic               r_last_owner;
    logic               w_can_accept;
    logic               w_xfer0;
    logic               w_xfer1;
    logic               w_burst_end;

    // Readiness depends only on grant state and output-slot space, never on valid.
    assign w_can_accept = !valid_out || out_ready;
    assign ready0       = (r_state == GRANT0) && w_can_accept;
    assign ready1       = (r_state == GRANT1) && w_can_accept;
    assign w_xfer0      = valid0 && ready0;
    assign w_xfer1      = valid1 && ready1;
    assign w_burst_end  = (r_burst_cnt == C_LAST_BEAT);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= IDLE;
            r_burst_cnt  <= '0;
            r_last_owner <= 1'b1;
        end else begin
            r_state     <= w_state_nxt;
            r_burst_cnt <= w_burst_cnt_nxt;
            if (w_xfer0) begin
                r_last_owner <= 1'b0;
            end else if (w_xfer1) begin
                r_last_owner <= 1'b1;
            end
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_burst_cnt_nxt = r_burst_cnt;
        case (r_state)
            IDLE: begin
                w_burst_cnt_nxt = '0;
                if (valid0 && valid1) begin
                    w_state_nxt = r_last_owner ? GRANT0 : GRANT1;
                end else if (valid0) begin
                    w_state_nxt = GRANT0;
                end else if (valid1) begin
                    w_state_nxt = GRANT1;
                end
            end
            GRANT0: begin
                // A full burst or a dropped valid both hand the grant on.
                if ((w_xfer0 && w_burst_end) || !valid0) begin
                    w_burst_cnt_nxt = '0;
                    if (valid1) begin
                        w_state_nxt = GRANT1;
                    end else if (valid0) begin
                        w_state_nxt = GRANT0;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end else if (w_xfer0) begin
                    w_burst_cnt_nxt = r_burst_cnt + C_ONE;
                end
            end
            GRANT1: begin
                if ((w_xfer1 && w_burst_end) || !valid1) begin
                    w_burst_cnt_nxt = '0;
                    if (valid0) begin
                        w_state_nxt = GRANT0;
                    end else if (valid1) begin
                        w_state_nxt = GRANT1;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end else if (w_xfer1) begin
                    w_burst_cnt_nxt = r_burst_cnt + C_ONE;
                end
            end
            default: begin
                w_state_nxt     = IDLE;
                w_burst_cnt_nxt = '0;
            end
        endcase
    end

    // Output slot: a new transfer overwrites it; otherwise a consume empties it.
    always_ff @(posedge clk) begin
        if (reset) begin
            out       <= '0;
            valid_out <= 1'b0;
            sel       <= 1'b0;
        end else if (w_xfer0) begin
            out       <= in0;
            sel       <= 1'b0;
            valid_out <= 1'b1;
        end else if (w_xfer1) begin
            out       <= in1;
            sel       <= 1'b1;
            valid_out <= 1'b1;
        end else if (out_ready) begin
            valid_out <= 1'b0;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mux2x1_arbiter.sv
// ============================================================================
// tb_mux2x1_arbiter : directed and random checks of two arbiter instances
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mux2x1_arbiter;

    localparam int MB_A = 4;
    localparam int MB_B = 1;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] in0, in1;
    logic       valid0, valid1, out_ready;

    logic       ready0_a, ready1_a, valid_out_a, sel_a;
    logic [7:0] out_a;
    logic       ready0_b, ready1_b, valid_out_b, sel_b;
    logic [7:0] out_b;

    always #5 clk = ~clk;

    mux2x1_arbiter #(.WIDTH(8), .MAX_BURST(MB_A), .CNT_W(8)) u_a (
        .clk(clk), .reset(reset),
        .in0(in0), .valid0(valid0), .ready0(ready0_a),
        .in1(in1), .valid1(valid1), .ready1(ready1_a),
        .out(out_a), .valid_out(valid_out_a), .out_ready(out_ready), .sel(sel_a)
    );

    mux2x1_arbiter #(.WIDTH(8), .MAX_BURST(MB_B), .CNT_W(8)) u_b (
        .clk(clk), .reset(reset),
        .in0(in0), .valid0(valid0), .ready0(ready0_b),
        .in1(in1), .valid1(valid1), .ready1(ready1_b),
        .out(out_b), .valid_out(valid_out_b), .out_ready(out_ready), .sel(sel_b)
    );

    // Reference model: owner (-1 none), beats taken this grant, last lane served,
    // and the single output slot contents.
    int         m_owner [2];
    int         m_beats [2];
    int         m_prev  [2];
    bit         m_full  [2];
    logic [7:0] m_data  [2];
    bit         m_src   [2];
    bit         took0, took1;

    int compared = 0;
    int mism     = 0;

    logic [8:0] obs_log [$];
    int         n0, n1;
    logic [7:0] base0, base1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mism++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset(input int k);
        m_owner[k] = -1;
        m_beats[k] = 0;
        m_prev[k]  = 1;
        m_full[k]  = 1'b0;
        m_data[k]  = 8'h00;
        m_src[k]   = 1'b0;
    endtask

    task automatic model_check(input int k, input string p, input logic r0, input logic r1,
                               input logic vo, input logic s, input logic [7:0] o);
        bit room;
        room = !m_full[k] || out_ready;
        chk({p, "ready0"},    r0, 32'((m_owner[k] == 0) && room));
        chk({p, "ready1"},    r1, 32'((m_owner[k] == 1) && room));
        chk({p, "valid_out"}, vo, 32'(m_full[k]));
        chk({p, "out"},       o,  32'(m_data[k]));
        chk({p, "sel"},       s,  32'(m_src[k]));
    endtask

    task automatic model_step(input int k);
        int         mb, o;
        bit         v [2];
        logic [7:0] d [2];
        bit         room, take;
        mb   = (k == 0) ? MB_A : MB_B;
        v[0] = valid0; v[1] = valid1;
        d[0] = in0;    d[1] = in1;
        if (k == 0) begin
            took0 = 1'b0;
            took1 = 1'b0;
        end
        if (reset) begin
            model_reset(k);
            return;
        end
        room = !m_full[k] || out_ready;
        take = 1'b0;
        o    = m_owner[k];
        if (o >= 0) take = v[o] && room;
        if (take) begin
            m_data[k] = d[o];
            m_src[k]  = (o == 1);
            m_full[k] = 1'b1;
            m_prev[k] = o;
            m_beats[k]++;
            if (k == 0 && o == 0) took0 = 1'b1;
            if (k == 0 && o == 1) took1 = 1'b1;
        end else if (m_full[k] && out_ready) begin
            m_full[k] = 1'b0;
        end
        if (o < 0) begin
            m_beats[k] = 0;
            if (v[0] && v[1])  m_owner[k] = 1 - m_prev[k];
            else if (v[0])     m_owner[k] = 0;
            else if (v[1])     m_owner[k] = 1;
            else               m_owner[k] = -1;
        end else if ((take && m_beats[k] == mb) || !v[o]) begin
            m_beats[k] = 0;
            if (v[1 - o])      m_owner[k] = 1 - o;
            else if (v[o])     m_owner[k] = o;
            else               m_owner[k] = -1;
        end
    endtask

    task automatic cycle(input logic rst, input logic v0, input logic v1, input logic ordy,
                         input logic [7:0] d0, input logic [7:0] d1);
        @(negedge clk);
        reset = rst; valid0 = v0; valid1 = v1; out_ready = ordy; in0 = d0; in1 = d1;
        #1;
        model_check(0, "a.", ready0_a, ready1_a, valid_out_a, sel_a, out_a);
        model_check(1, "b.", ready0_b, ready1_b, valid_out_b, sel_b, out_b);
        if (valid_out_a && out_ready) obs_log.push_back({sel_a, out_a});
        model_step(0);
        model_step(1);
    endtask

    // Lanes present base+n, advancing n each time the model says lane accepted.
    task automatic stream(input int n, input logic v0, input logic v1, input logic ordy);
        for (int i = 0; i < n; i++) begin
            cycle(1'b0, v0, v1, ordy, base0 + 8'(n0), base1 + 8'(n1));
            if (took0) n0++;
            if (took1) n1++;
        end
    endtask

    initial begin
        logic [7:0] e;
        logic [8:0] entry;
        int         guard;

        reset = 1'b1; valid0 = 1'b0; valid1 = 1'b0; out_ready = 1'b1;
        in0 = 8'h00; in1 = 8'h00;
        repeat (2) @(posedge clk);
        model_reset(0);
        model_reset(1);

        // Lane 0 alone: 11, 22, 33 after one idle cycle.
        obs_log.delete();
        cycle(0, 1, 0, 1, 8'h11, 8'h00);
        chk("s1_idle_ready0", ready0_a, 0);
        cycle(0, 1, 0, 1, 8'h11, 8'h00);
        chk("s1_grant_ready0", ready0_a, 1);
        cycle(0, 1, 0, 1, 8'h22, 8'h00);
        chk("s1_out11", out_a, 8'h11);
        cycle(0, 1, 0, 1, 8'h33, 8'h00);
        chk("s1_out22", out_a, 8'h22);
        cycle(0, 0, 0, 1, 8'h00, 8'h00);
        chk("s1_out33", out_a, 8'h33);
        chk("s1_ready1", ready1_a, 0);
        cycle(0, 0, 0, 1, 8'h00, 8'h00);

        // Both lanes streaming after reset: A0..A3, B0..B3, A4..A7.
        cycle(1, 0, 0, 1, 8'h00, 8'h00);
        obs_log.delete();
        base0 = 8'hA0; base1 = 8'hB0; n0 = 0; n1 = 0;
        stream(14, 1, 1, 1);
        chk("s2_count", obs_log.size(), 12);
        for (int i = 0; i < 12 && i < obs_log.size(); i++) begin
            e     = (((i / 4) % 2) == 1) ? 8'hB0 : 8'hA0;
            e     = e + 8'((i / 8) * 4 + (i % 4));
            entry = obs_log[i];
            chk("s2_beat", entry, {1'((i / 4) % 2), e});
        end
        stream(2, 0, 0, 1);

        // Lane 1 alone for six beats crosses a burst boundary without idling.
        obs_log.delete();
        base1 = 8'hC0; n1 = 0; guard = 0;
        while (n1 < 6 && guard < 20) begin
            stream(1, 0, 1, 1);
            guard++;
        end
        chk("s3_timeout", 32'(n1), 6);
        stream(3, 0, 0, 1);
        chk("s3_count", obs_log.size(), 6);
        for (int i = 0; i < 6 && i < obs_log.size(); i++) begin
            entry = obs_log[i];
            chk("s3_beat", entry, {1'b1, 8'hC0 + 8'(i)});
        end

        // Backpressure in the middle of a lane 0 burst.
        cycle(0, 1, 0, 1, 8'h11, 8'h00);
        cycle(0, 1, 0, 1, 8'h11, 8'h00);
        cycle(0, 1, 0, 1, 8'h22, 8'h00);
        for (int i = 0; i < 3; i++) begin
            cycle(0, 1, 0, 0, 8'h33, 8'h00);
            chk("s4_hold_out", out_a, 8'h22);
            chk("s4_hold_valid", valid_out_a, 1);
            chk("s4_hold_ready0", ready0_a, 0);
        end
        cycle(0, 1, 0, 1, 8'h33, 8'h00);
        cycle(0, 0, 0, 1, 8'h00, 8'h00);
        chk("s4_release_out", out_a, 8'h33);
        cycle(0, 0, 0, 1, 8'h00, 8'h00);

        // Reset pulse mid-burst, then lane 0 wins the tie.
        cycle(0, 1, 1, 1, 8'h51, 8'h61);
        cycle(0, 1, 1, 1, 8'h52, 8'h62);
        cycle(1, 1, 1, 1, 8'h53, 8'h63);
        cycle(0, 1, 1, 1, 8'h54, 8'h64);
        chk("s5_valid_out", valid_out_a, 0);
        chk("s5_out", out_a, 8'h00);
        chk("s5_idle_ready0", ready0_a, 0);
        cycle(0, 1, 1, 1, 8'h54, 8'h64);
        chk("s5_first_ready0", ready0_a, 1);
        chk("s5_first_ready1", ready1_a, 0);
        cycle(0, 0, 0, 1, 8'h00, 8'h00);
        cycle(0, 0, 0, 1, 8'h00, 8'h00);

        // Lane 0 drops valid after two beats with lane 1 waiting.
        obs_log.delete();
        base0 = 8'hD0; base1 = 8'hE0; n0 = 0; n1 = 0;
        stream(1, 1, 0, 1);
        stream(2, 1, 1, 1);
        stream(1, 0, 1, 1);
        stream(2, 0, 1, 1);
        stream(3, 0, 0, 1);
        chk("s6_count", obs_log.size(), 4);
        if (obs_log.size() == 4) begin
            chk("s6_b0", obs_log[0], {1'b0, 8'hD0});
            chk("s6_b1", obs_log[1], {1'b0, 8'hD1});
            chk("s6_b2", obs_log[2], {1'b1, 8'hE0});
            chk("s6_b3", obs_log[3], {1'b1, 8'hE1});
        end

        // Random traffic, occasional reset, checked cycle by cycle.
        for (int i = 0; i < 600; i++) begin
            cycle(($urandom_range(63) == 0),
                  ($urandom_range(9) < 7), ($urandom_range(9) < 7),
                  ($urandom_range(9) < 7),
                  8'($urandom), 8'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mism);
        $finish;
    end

endmodule

`default_nettype wire
